// File: rtl/ble_packet_sequencer_if.sv
// ble_packet_sequencer_if: recovered bit stream in, byte stream with valid/ready out
interface ble_packet_sequencer_if;
    logic       update;
    logic       value;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;
    logic       byte_last;
    modport master (output update, value, byte_ready, input byte_out, byte_valid, byte_last);
    modport slave  (input update, value, byte_ready, output byte_out, byte_valid, byte_last);
endinterface

// File: rtl/ble_packet_sequencer.sv
// ble_packet_sequencer: access-address search, packet framing, de-whitening and byte FIFO
module ble_packet_sequencer #(
    parameter logic [31:0] ACCESS_ADDR = 32'h8E89BED6,
    parameter int          AA_MAX_ERR  = 0,
    parameter int          MAX_LEN     = 37,
    parameter int          TIMEOUT     = 64,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_rx_en,
    input  logic                         i_dewhiten_en,
    input  logic [5:0]                   i_chan_idx,
    ble_packet_sequencer_if.slave        bif,
    output logic                         o_sync_det,
    output logic                         o_pkt_active,
    output logic                         o_pkt_done,
    output logic                         o_pkt_err,
    output logic [1:0]                   o_err_code
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {SEARCH, HEADER, PAYLOAD, CRC} state_t;
    state_t          r_state, w_state_n;
    logic            r_update_q, r_push, r_push_last, r_sync_det, r_pkt_err;
    logic [31:0]     r_sr;
    logic [6:0]      r_w;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_byte, r_byte_cnt, r_len, r_push_data;
    logic [TW-1:0]   r_to_cnt;
    logic [1:0]      r_err_code, w_code;
    logic [8:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wp, r_rp;
    logic [AW:0]     r_cnt;
    logic            w_bit, w_in_pkt, w_d, w_byte_done, w_match, w_sync, w_abort, w_last_byte;
    logic            w_to, w_push, w_pop, w_full, w_ovf, w_wr, w_flush, w_valid;
    logic [31:0]     w_sr_sh;
    logic [7:0]      w_byte;
    assign w_bit       = bif.update & ~r_update_q & i_rx_en;
    assign w_in_pkt    = r_state != SEARCH;
    assign w_d         = bif.value ^ (i_dewhiten_en & r_w[6]);
    assign w_byte      = {w_d, r_byte[7:1]};
    assign w_byte_done = w_bit & w_in_pkt & (r_bit_cnt == 3'd7);
    assign w_sr_sh     = {bif.value, r_sr[31:1]};
    assign w_match     = $countones(w_sr_sh ^ ACCESS_ADDR) <= AA_MAX_ERR;
    // a bit event in the cycle the counter expires keeps the packet alive
    assign w_to        = i_rx_en & w_in_pkt & ~w_bit & (r_to_cnt == TW'(TIMEOUT - 1));
    assign w_valid     = r_cnt != '0;
    assign w_push      = r_push & i_rx_en;
    assign w_pop       = w_valid & bif.byte_ready;
    assign w_full      = r_cnt == (AW + 1)'(FIFO_DEPTH);
    assign w_ovf       = w_push & w_full & ~w_pop;
    assign w_wr        = w_push & ~w_ovf;
    // a length abort keeps the FIFO so both header bytes still reach the consumer
    assign w_flush     = ~i_rx_en | w_to | w_ovf;
    always_comb begin
        w_state_n   = r_state;
        w_sync      = 1'b0;
        w_last_byte = 1'b0;
        w_abort     = 1'b0;
        w_code      = 2'd1;
        case (r_state)
            SEARCH: if (w_bit && w_match) begin
                w_state_n = HEADER;
                w_sync    = 1'b1;
            end
            HEADER: if (w_byte_done && r_byte_cnt == 8'd1) begin
                w_abort   = w_byte > 8'(MAX_LEN);
                w_state_n = w_abort ? SEARCH : (w_byte == 8'd0) ? CRC : PAYLOAD;
            end
            PAYLOAD: if (w_byte_done && r_byte_cnt == r_len - 8'd1) w_state_n = CRC;
            default: if (w_byte_done && r_byte_cnt == 8'd2) begin
                w_state_n   = SEARCH;
                w_last_byte = 1'b1;
            end
        endcase
        if (w_to || w_ovf) begin
            w_abort   = 1'b1;
            w_code    = w_ovf ? 2'd3 : 2'd2;
            w_state_n = SEARCH;
            w_sync    = 1'b0;
        end
        if (!i_rx_en) w_state_n = SEARCH;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= SEARCH;
            r_update_q  <= 1'b0;
            r_sync_det  <= 1'b0;
            r_pkt_err   <= 1'b0;
            r_err_code  <= 2'd0;
            r_sr        <= '0;
            r_w         <= '0;
            r_bit_cnt   <= '0;
            r_byte      <= '0;
            r_byte_cnt  <= '0;
            r_len       <= '0;
            r_push      <= 1'b0;
            r_push_data <= '0;
            r_push_last <= 1'b0;
            r_to_cnt    <= '0;
            r_wp        <= '0;
            r_rp        <= '0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_n;
            r_update_q  <= bif.update;
            r_sync_det  <= w_sync;
            r_pkt_err   <= w_abort;
            r_err_code  <= w_abort ? w_code : w_sync ? 2'd0 : r_err_code;
            r_sr        <= (w_in_pkt || !i_rx_en || w_abort) ? '0 : w_bit ? w_sr_sh : r_sr;
            r_w         <= w_sync ? {i_chan_idx[0], i_chan_idx[1], i_chan_idx[2], i_chan_idx[3],
                                     i_chan_idx[4], i_chan_idx[5], 1'b1}
                         : (w_bit && w_in_pkt) ? {r_w[5], r_w[4], r_w[3] ^ r_w[6], r_w[2], r_w[1], r_w[0], r_w[6]}
                         : r_w;
            r_bit_cnt   <= w_sync ? '0 : (w_bit && w_in_pkt) ? r_bit_cnt + 3'd1 : r_bit_cnt;
            r_byte      <= (w_bit && w_in_pkt) ? w_byte : r_byte;
            r_byte_cnt  <= w_sync ? '0 : w_byte_done ? ((w_state_n != r_state) ? '0 : r_byte_cnt + 8'd1) : r_byte_cnt;
            r_len       <= (w_byte_done && r_state == HEADER && r_byte_cnt == 8'd1) ? w_byte : r_len;
            r_push      <= w_byte_done;
            r_push_data <= w_byte;
            r_push_last <= w_last_byte;
            r_to_cnt    <= w_bit ? TW'(1) : w_in_pkt ? r_to_cnt + TW'(1) : '0;
            r_wp        <= w_flush ? '0 : r_wp + AW'(w_wr);
            r_rp        <= w_flush ? '0 : r_rp + AW'(w_pop);
            r_cnt       <= w_flush ? '0 : r_cnt + (AW + 1)'(w_wr) - (AW + 1)'(w_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wp] <= {r_push_last, r_push_data};
    end
    assign bif.byte_valid = w_valid;
    assign bif.byte_out   = w_valid ? r_mem[r_rp][7:0] : 8'd0;
    assign bif.byte_last  = w_valid & r_mem[r_rp][8];
    assign o_sync_det     = r_sync_det;
    assign o_pkt_active   = w_in_pkt;
    assign o_pkt_done     = r_push_last & w_wr;
    assign o_pkt_err      = r_pkt_err;
    assign o_err_code     = r_err_code;
endmodule

// File: doc/ble_packet_sequencer.md
Name: ble_packet_sequencer

Overview:
- Receive-side packet controller behind the matched filter / timing recovery pair.
- Consumes the recovered bit stream (`update` strobe plus `value` bit) and searches for the BLE access address.
- On match, frames the packet: 2 header bytes, LENGTH payload bytes, 3 CRC bytes. Optionally de-whitens, then delivers bytes through a small FIFO with valid/ready handshake.
- Aborts on bad length, bit-clock loss or FIFO overflow.

Parameters:
- ACCESS_ADDR, 32'h8E89BED6, access address to correlate (advertising AA).
- AA_MAX_ERR, 0, maximum bit mismatches (0..3) still accepted as sync.
- MAX_LEN, 37, largest legal LENGTH field; larger aborts.
- TIMEOUT, 64, clk cycles without a bit event before abort (16 MHz clk, 1 Mb/s nominal bit rate).
- FIFO_DEPTH, 4, output byte FIFO entries (power of 2).

Ports:
- clk  in  1  16 MHz ADC clock, single clock domain.
- rst  in  1  synchronous, active-high reset.
- rx_en  in  1  receive enable; low forces SEARCH and flushes FIFO.
- update  in  1  bit clock from timing recovery; a rising edge is one bit event.
- value  in  1  demodulated bit, valid in the bit-event cycle.
- dewhiten_en  in  1  1 = apply BLE de-whitening from header onward.
- chan_idx  in  6  channel index used to seed the whitening LFSR.
- byte_out  out  8  output byte (FIFO head).
- byte_valid  out  1  FIFO non-empty.
- byte_ready  in  1  consumer accepts; pop when valid & ready.
- byte_last  out  1  head byte is the final CRC byte.
- sync_det  out  1  one-cycle pulse on access-address match.
- pkt_active  out  1  high from sync until done or abort.
- pkt_done  out  1  one-cycle pulse when last CRC byte is pushed.
- pkt_err  out  1  one-cycle pulse on abort.
- err_code  out  2  last abort cause, held until next sync: 0 none, 1 length, 2 timeout, 3 overflow.

Behaviour:
- Reset: all outputs 0, FIFO empty, state SEARCH, shift register 0, err_code 0.
- Bit event:
  - `update_q` is the registered copy of `update`.
  - A bit event is `update & ~update_q`; `value` is sampled in that cycle.
  - Everything else advances only on bit events, except the timeout counter and FIFO pops.
- Bit order is LSB first. The 32-bit shift register shifts right with the new bit entering bit 31. In SEARCH, match when popcount(sr ^ ACCESS_ADDR) <= AA_MAX_ERR, evaluated on the post-shift value.
- SEARCH -> HEADER on match:
  - pulse sync_det and set pkt_active the next cycle;
  - seed the LFSR, clear the bit and byte counters, clear err_code.
- De-whitening LFSR w[6:0]:
  - Seed: w[0]=1, w[1]=chan_idx[5], w[2]=chan_idx[4], ..., w[6]=chan_idx[0].
  - Per header/payload/CRC bit: output bit = value ^ (dewhiten_en & w[6]).
  - Update: w <= {w[5], w[4], w[3]^w[6], w[2], w[1], w[0], w[6]}.
- Byte assembly: bits pack LSB first. On the 8th bit the byte is pushed the next cycle; byte_valid rises the cycle after the push.
- HEADER: 2 bytes. After the second byte, LENGTH = second header byte.
  - LENGTH > MAX_LEN: abort with code 1. Both header bytes are still pushed.
  - Otherwise go to PAYLOAD, or straight to CRC if LENGTH = 0.
- PAYLOAD: LENGTH bytes, then CRC.
- CRC: 3 bytes. The third byte is pushed with its byte_last flag set; pkt_done pulses in the push cycle; return to SEARCH with sr cleared.
- Timeout: the counter runs in HEADER, PAYLOAD and CRC and resets on every bit event. Reaching TIMEOUT aborts with code 2. A bit event in the same cycle as reaching TIMEOUT wins (no abort).
- Overflow: a push while the FIFO is full and not popping in that cycle aborts with code 3 and drops the byte. A push and pop in the same cycle while full is legal.
- Abort:
  - pkt_err pulses; pkt_active clears; state returns to SEARCH with sr cleared.
  - The FIFO is flushed next cycle; bytes already popped stand.
  - err_code latches the cause.
- rx_en low, any state: next cycle state = SEARCH, FIFO flushed, pkt_active = 0. No pkt_err, err_code unchanged.
- rst mid-packet: identical to the reset state next cycle; no pkt_done or pkt_err pulse.
- No CRC check in this block; the CRC bytes are passed downstream.

Test Plan:
- Clean packet: dewhiten off, byte_ready = 1, AA 0x8E89BED6 LSB first, header 0x02 0x03, payload 0x11 0x22 0x33, CRC 0xAA 0xBB 0xCC. Expect sync_det once; bytes out in order 02 03 11 22 33 AA BB CC; byte_last only on 0xCC; pkt_done once; pkt_err never.
- Near-miss AA: AA with 1 bit flipped and AA_MAX_ERR = 0 -> no sync_det. With AA_MAX_ERR = 1 -> sync_det, and the packet completes as above.
- Bad length: header 0x02 0x40 (64 > 37). Expect 02 40 delivered, pkt_err, err_code = 1, return to SEARCH; a following valid packet is received normally.
- Timeout: after 10 payload bits stop update toggling. Expect pkt_err exactly TIMEOUT cycles after the last bit event, err_code = 2, FIFO empty.
- Overflow: byte_ready held 0 during the clean packet. Expect 4 bytes buffered; the 5th push aborts with err_code = 3; FIFO flushed.
- Control: deassert rx_en mid-payload -> pkt_active = 0 next cycle, no pkt_err. Apply rst mid-header -> all outputs 0. Known-whitened packet on chan_idx 37 with dewhiten_en = 1 -> de-whitened bytes match the clean-packet sequence.
